// File: rtl/dreq_arbiter.sv
// -----------------------------------------------------------------------------
// dreq_arbiter
//
// Purpose:
//    Four-channel DMA request arbiter. It raises a hold request to the
//    processor when any unmasked channel requests service. Once hold is
//    acknowledged, it grants the bus to one channel, chosen by fixed or
//    rotating priority. The grant is held until end-of-transfer or until the
//    channel withdraws its demand. Then hold is released and the arbiter
//    waits for the processor to drop HLDA before accepting new work.
//    Two abnormal cases end the cycle with a one-cycle err pulse:
//    a missing HLDA (timeout) and HLDA lost during a grant.
//
// Parameters:
//    TIMEOUT      number of cycles HREQ is held waiting for HLDA (>= 1)
//
// Ports:
//    clk          system clock, all state changes on the rising edge
//    reset        asynchronous, active-low reset
//    DREQ[3:0]    level-sensitive per-channel DMA requests (bit n = channel n)
//    mask[3:0]    1 = channel ignored when a new winner is chosen
//    rotate       priority mode: 0 fixed (ch0 highest), 1 rotating
//    HLDA         hold acknowledge from the processor
//    eop          one-cycle end-of-transfer pulse from the DMA datapath
//    HREQ         hold request to the processor
//    DACK[3:0]    one-hot acknowledge of the granted channel, zero otherwise
//    grant_ch     index of the granted channel, 0 when no grant
//    grant_valid  high while a channel owns the bus
//    err          one-cycle pulse on HLDA timeout or HLDA loss during grant
// -----------------------------------------------------------------------------
module dreq_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] DREQ,
   input  logic [3:0] mask,
   input  logic       rotate,
   input  logic       HLDA,
   input  logic       eop,
   output logic       HREQ,
   output logic [3:0] DACK,
   output logic [1:0] grant_ch,
   output logic       grant_valid,
   output logic       err
);

   // The counter only has to represent 0 .. TIMEOUT-1.
   // The last value is the cycle on which the request is abandoned.
   localparam int            CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_GRANT   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [1:0]      ch_q,    ch_d;    // latched winner
   logic [1:0]      ptr_q,   ptr_d;   // highest-priority channel in rotating mode
   logic            err_q,   err_d;

   // -------------------------------------------------------------------------
   // Winner selection
   // -------------------------------------------------------------------------
   logic [3:0] req_vec;
   logic [7:0] req_dbl;
   logic [3:0] req_rot;
   logic [1:0] start_ch;
   logic [1:0] win_off;
   logic [1:0] win_ch;
   logic       win_found;

   assign req_vec   = DREQ & ~mask;
   assign win_found = |req_vec;
   assign start_ch  = rotate ? ptr_q : 2'd0;

   // Rotate the request vector so that the highest-priority channel sits at
   // bit 0. A plain lowest-bit priority encoder then yields the winner's
   // offset from start_ch. The doubled vector makes the wrap-around a slice.
   assign req_dbl = {req_vec, req_vec};
   assign req_rot = req_dbl[start_ch +: 4];

   always_comb begin
      win_off = 2'd3;
      if (req_rot[0]) begin
         win_off = 2'd0;
      end else if (req_rot[1]) begin
         win_off = 2'd1;
      end else if (req_rot[2]) begin
         win_off = 2'd2;
      end
   end

   // Two-bit addition wraps modulo 4, which is exactly the channel ring.
   assign win_ch = start_ch + win_off;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ch_q    <= 2'd0;
         ptr_q   <= 2'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;            // counter is only live while in ST_REQ
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d = ST_REQ;
            end
         end

         ST_REQ: begin
            // An acknowledge in the last counted cycle still wins over the timeout.
            if (HLDA) begin
               if (win_found) begin
                  ch_d    = win_ch;
                  state_d = ST_GRANT;
               end else begin
                  // Every request went away while we waited.
                  // Hand the bus straight back.
                  state_d = ST_RELEASE;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_GRANT: begin
            // Losing HLDA is checked first, so a simultaneous eop is dropped.
            // In that case the rotation pointer is left untouched.
            // Mask changes are deliberately not looked at here. Only the
            // granted channel's own DREQ can end the grant.
            if (!HLDA) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (eop || !DREQ[ch_q]) begin
               state_d = ST_RELEASE;
               // The pointer always follows the last completed grant.
               // It only takes effect while rotate=1.
               ptr_d   = ch_q + 2'd1;
            end
         end

         ST_RELEASE: begin
            if (!HLDA) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from registered state.
   // They take their reset values as soon as reset is asserted.
   // -------------------------------------------------------------------------
   assign HREQ        = (state_q == ST_REQ) || (state_q == ST_GRANT);
   assign grant_valid = (state_q == ST_GRANT);
   assign grant_ch    = grant_valid ? ch_q : 2'd0;
   assign err         = err_q;

   // One-hot by construction: at most one bit can match ch_q.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dack
         assign DACK[gi] = grant_valid && (ch_q == 2'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_dreq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dreq_arbiter
//
// Directed scenarios for the documented behaviours, followed by random
// traffic. The random traffic is checked every cycle against a behavioural
// model of the arbiter's rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dreq_arbiter;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] DREQ;
   logic [3:0] mask;
   logic       rotate;
   logic       HLDA;
   logic       eop;
   logic       HREQ;
   logic [3:0] DACK;
   logic [1:0] grant_ch;
   logic       grant_valid;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dreq_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .DREQ        (DREQ),
      .mask        (mask),
      .rotate      (rotate),
      .HLDA        (HLDA),
      .eop         (eop),
      .HREQ        (HREQ),
      .DACK        (DACK),
      .grant_ch    (grant_ch),
      .grant_valid (grant_valid),
      .err         (err)
   );

   // Step to 1 ns after the next rising edge.
   // Outputs are sampled and inputs driven there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b0;
      DREQ   = 4'b0;
      mask   = 4'b0;
      rotate = 1'b0;
      HLDA   = 1'b0;
      eop    = 1'b0;
      tick();
      tick();
      reset  = 1'b1;
   endtask

   task automatic wait_hreq(input logic level, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (HREQ === level) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_gv(input logic level, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (grant_valid === level) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b0; DREQ = 4'hF; mask = 4'h0; rotate = 1'b0; HLDA = 1'b1; eop = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({HREQ, DACK, grant_ch, grant_valid, err} !== 9'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b expected %b",
                  {HREQ, DACK, grant_ch, grant_valid, err}, 9'b0);
      end
      reset = 1'b1; DREQ = 4'h0; HLDA = 1'b0; eop = 1'b0;
      tick();
      n_cmp++;
      if (HREQ !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release_idle: got HREQ=%b err=%b expected 0 0", HREQ, err);
      end
   endtask

   // Fixed priority on 1010 picks ch1; eop releases; HLDA low returns to idle.
   task automatic test_fixed_basic();
      do_reset();
      DREQ = 4'b1010;
      tick();
      n_cmp++;
      if (HREQ !== 1'b1 || DACK !== 4'b0) begin
         n_bad++;
         $display("FAIL fixed_req: got HREQ=%b DACK=%b expected 1 0000", HREQ, DACK);
      end
      tick();
      HLDA = 1'b1;
      tick();
      n_cmp++;
      if (DACK !== 4'b0010 || grant_ch !== 2'd1 || grant_valid !== 1'b1 || HREQ !== 1'b1) begin
         n_bad++;
         $display("FAIL fixed_grant: got DACK=%b ch=%0d gv=%b HREQ=%b expected 0010 1 1 1",
                  DACK, grant_ch, grant_valid, HREQ);
      end
      tick();
      eop = 1'b1;
      tick();
      eop = 1'b0;
      n_cmp++;
      if (HREQ !== 1'b0 || DACK !== 4'b0 || grant_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL fixed_release: got HREQ=%b DACK=%b gv=%b expected 0 0000 0",
                  HREQ, DACK, grant_valid);
      end
      HLDA = 1'b0; DREQ = 4'b0;
      tick();
      DREQ = 4'b0001;
      tick();
      n_cmp++;
      if (HREQ !== 1'b1 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL fixed_back_to_idle: got HREQ=%b err=%b expected 1 0", HREQ, err);
      end
   endtask

   task automatic test_rotate_order();
      bit ok;
      int exp_ch;
      do_reset();
      rotate = 1'b1; DREQ = 4'hF;
      for (int g = 0; g < 5; g++) begin
         exp_ch = g % 4;
         wait_hreq(1'b1, ok);
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL rotate_hreq_wait: grant %0d got no HREQ expected HREQ=1", g);
         end
         HLDA = 1'b1;
         wait_gv(1'b1, ok);
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL rotate_grant_wait: grant %0d got no grant_valid expected 1", g);
         end
         n_cmp++;
         if (grant_ch !== 2'(exp_ch) || DACK !== 4'(1 << exp_ch)) begin
            n_bad++;
            $display("FAIL rotate_order: grant %0d got ch=%0d DACK=%b expected ch=%0d",
                     g, grant_ch, DACK, exp_ch);
         end
         eop = 1'b1;
         tick();
         eop = 1'b0;
         n_cmp++;
         if (HREQ !== 1'b0 || grant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rotate_release: grant %0d got HREQ=%b gv=%b expected 0 0",
                     g, HREQ, grant_valid);
         end
         HLDA = 1'b0;
         tick();
      end
   endtask

   task automatic test_timeout();
      int n_high;
      bit done;
      do_reset();
      DREQ = 4'b0001;
      n_high = 0;
      done = 1'b0;
      for (int i = 0; i < TIMEOUT + 10; i++) begin
         tick();
         if (HREQ === 1'b1) begin
            n_high++;
         end else if (n_high > 0) begin
            done = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!done || n_high != TIMEOUT) begin
         n_bad++;
         $display("FAIL timeout_len: got %0d HREQ cycles (dropped=%0b) expected %0d",
                  n_high, done, TIMEOUT);
      end
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_err: got err=%b expected 1", err);
      end
      DREQ = 4'b0;
      tick();
      n_cmp++;
      if (err !== 1'b0 || HREQ !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_err_pulse: got err=%b HREQ=%b expected 0 0", err, HREQ);
      end
   endtask

   task automatic test_hlda_loss(input logic with_eop);
      do_reset();
      DREQ = 4'b0100;
      tick();
      HLDA = 1'b1;
      tick();
      n_cmp++;
      if (DACK !== 4'b0100 || grant_ch !== 2'd2) begin
         n_bad++;
         $display("FAIL hlda_loss_grant(eop=%b): got DACK=%b ch=%0d expected 0100 2",
                  with_eop, DACK, grant_ch);
      end
      HLDA = 1'b0; eop = with_eop;
      tick();
      eop = 1'b0;
      n_cmp++;
      if ({HREQ, DACK, grant_valid, err} !== 7'b0_0000_0_1) begin
         n_bad++;
         $display("FAIL hlda_loss_abort(eop=%b): got HREQ=%b DACK=%b gv=%b err=%b expected 0 0000 0 1",
                  with_eop, HREQ, DACK, grant_valid, err);
      end
      // Still-pending DREQ must re-request at once from IDLE.
      // A RELEASE state would not do this.
      tick();
      n_cmp++;
      if (HREQ !== 1'b1 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL hlda_loss_idle(eop=%b): got HREQ=%b err=%b expected 1 0",
                  with_eop, HREQ, err);
      end
   endtask

   task automatic test_mask_withdraw();
      bit bad;
      do_reset();
      DREQ = 4'b0100; mask = 4'b0100;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (HREQ !== 1'b0) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin
         n_bad++;
         $display("FAIL masked_no_hreq: got HREQ=1 while masked expected 0");
      end
      mask = 4'b0;
      tick();
      DREQ = 4'b0; HLDA = 1'b1;
      tick();
      n_cmp++;
      if (HREQ !== 1'b0 || DACK !== 4'b0 || grant_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL withdraw_release: got HREQ=%b DACK=%b gv=%b expected 0 0000 0",
                  HREQ, DACK, grant_valid);
      end
      // RELEASE holds while HLDA stays high, even with a new request.
      DREQ = 4'b0100;
      tick();
      n_cmp++;
      if (HREQ !== 1'b0 || DACK !== 4'b0) begin
         n_bad++;
         $display("FAIL withdraw_hold: got HREQ=%b DACK=%b expected 0 0000", HREQ, DACK);
      end
      HLDA = 1'b0;
      tick();
      n_cmp++;
      if (HREQ !== 1'b0) begin
         n_bad++;
         $display("FAIL withdraw_idle: got HREQ=%b expected 0", HREQ);
      end
      tick();
      n_cmp++;
      if (HREQ !== 1'b1) begin
         n_bad++;
         $display("FAIL withdraw_rereq: got HREQ=%b expected 1", HREQ);
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      DREQ = 4'b1000; HLDA = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (DACK !== 4'b1000 || grant_ch !== 2'd3) begin
         n_bad++;
         $display("FAIL reset_grant_setup: got DACK=%b ch=%0d expected 1000 3", DACK, grant_ch);
      end
      #3;
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({HREQ, DACK, grant_ch, grant_valid, err} !== 9'b0) begin
         n_bad++;
         $display("FAIL reset_async: got %b expected %b",
                  {HREQ, DACK, grant_ch, grant_valid, err}, 9'b0);
      end
      HLDA = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      n_cmp++;
      if (HREQ !== 1'b1 || err !== 1'b0 || DACK !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_rearb_req: got HREQ=%b err=%b DACK=%b expected 1 0 0000",
                  HREQ, err, DACK);
      end
      HLDA = 1'b1;
      tick();
      n_cmp++;
      if (DACK !== 4'b1000) begin
         n_bad++;
         $display("FAIL reset_rearb_grant: got DACK=%b expected 1000", DACK);
      end
   endtask

   // Highest-priority requester, scanning upward from 'start' around the ring.
   function automatic int pick(input logic [3:0] req, input int start);
      for (int k = 0; k < 4; k++) begin
         if (req[(start + k) % 4]) return (start + k) % 4;
      end
      return 0;
   endfunction

   task automatic test_random(input logic rot, input int cycles);
      // Phases of a hold cycle: 0 idle, 1 requesting, 2 granted, 3 releasing.
      int         ph;
      int         waited;
      int         ptr;
      int         m_ch;
      logic       e_err;
      logic       e_hreq;
      logic       e_gv;
      logic [3:0] e_dack;
      logic [1:0] e_ch;
      logic [3:0] req;
      do_reset();
      rotate = rot;
      ph = 0; waited = 0; ptr = 0; m_ch = 0;
      for (int c = 0; c < cycles; c++) begin
         if ($urandom_range(5) == 0) DREQ = 4'($urandom);
         if ($urandom_range(7) == 0) mask = 4'($urandom);
         if ($urandom_range(5) == 0) HLDA = ~HLDA;
         eop = ($urandom_range(7) == 0);

         req   = DREQ & ~mask;
         e_err = 1'b0;
         case (ph)
            0: if (req != 4'b0) begin
                  ph = 1;
                  waited = 0;
               end
            1: if (HLDA) begin
                  if (req != 4'b0) begin
                     m_ch = pick(req, rot ? ptr : 0);
                     ph = 2;
                  end else begin
                     ph = 3;
                  end
               end else begin
                  waited++;
                  if (waited == TIMEOUT) begin
                     ph = 0;
                     e_err = 1'b1;
                  end
               end
            2: if (!HLDA) begin
                  ph = 0;
                  e_err = 1'b1;
               end else if (eop || !DREQ[m_ch]) begin
                  ptr = (m_ch + 1) % 4;
                  ph = 3;
               end
            default: if (!HLDA) ph = 0;
         endcase
         e_hreq = (ph == 1) || (ph == 2);
         e_gv   = (ph == 2);
         e_dack = e_gv ? 4'(1 << m_ch) : 4'b0;
         e_ch   = e_gv ? 2'(m_ch) : 2'd0;

         tick();
         n_cmp++;
         if ({HREQ, DACK, grant_ch, grant_valid, err} !== {e_hreq, e_dack, e_ch, e_gv, e_err}) begin
            n_bad++;
            $display("FAIL random(rot=%b) cycle %0d: got HREQ=%b DACK=%b ch=%0d gv=%b err=%b expected %b %b %0d %b %b",
                     rot, c, HREQ, DACK, grant_ch, grant_valid, err,
                     e_hreq, e_dack, e_ch, e_gv, e_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_basic();
      test_rotate_order();
      test_timeout();
      test_hlda_loss(1'b0);
      test_hlda_loss(1'b1);
      test_mask_withdraw();
      test_reset_mid_grant();
      test_random(1'b0, 800);
      test_random(1'b1, 800);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected finish before 2 ms");
      $fatal(1);
   end

endmodule

// File: doc/dreq_arbiter.md
DREQ_ARBITER -- requirements
Module: dreq_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles HREQ waits for HLDA before the request is abandoned.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 DREQ  input  4  per-channel DMA request, level-sensitive, bit n = channel n.
REQ-005 mask  input  4  per-channel mask; 1 = channel ignored for new arbitration.
REQ-006 rotate  input  1  priority mode: 0 fixed (ch0 highest), 1 rotating.
REQ-007 HLDA  input  1  hold acknowledge from the processor.
REQ-008 eop  input  1  one-cycle end-of-transfer pulse from the DMA datapath.
REQ-009 HREQ  output  1  hold request to the processor.
REQ-010 DACK  output  4  one-hot channel acknowledge; all zero when no grant.
REQ-011 grant_ch  output  2  index of the granted channel, valid while grant_valid=1.
REQ-012 grant_valid  output  1  high while a channel owns the bus.
REQ-013 err  output  1  one-cycle pulse on HLDA timeout or HLDA loss during grant.

Function
REQ-014 States: IDLE, REQ, GRANT, RELEASE; exactly one active; encoding is free.
REQ-015 IDLE: when any (DREQ & ~mask) bit is 1, assert HREQ and go to REQ next cycle.
REQ-016 REQ: HREQ=1; timeout counter increments each cycle from 0.
REQ-017 REQ, HLDA=1 sampled: select winner from current (DREQ & ~mask) by active priority, latch it, go to GRANT; DACK and grant_valid assert on the following edge.
REQ-018 REQ, HLDA=1 but no unmasked DREQ remaining: go to RELEASE, no DACK issued.
REQ-019 REQ, counter reaches TIMEOUT with HLDA=0: drop HREQ, pulse err, go to IDLE; counter clears.
REQ-020 Fixed priority: channel 0 highest, channel 3 lowest.
REQ-021 Rotating priority: after a grant to channel n completes, channel n becomes lowest and (n+1) mod 4 highest; rotation pointer resets to ch0-highest.
REQ-022 GRANT: HREQ=1, DACK one-hot at latched channel, grant_ch = latched channel, grant_valid=1.
REQ-023 GRANT ends on eop=1 or on DREQ of the granted channel falling to 0 (demand end), whichever first; go to RELEASE; rotation pointer updates on this edge.
REQ-024 Mask or DREQ changes on non-granted channels during GRANT shall not affect the grant.
REQ-025 GRANT, HLDA falls to 0: drop DACK, grant_valid, HREQ next edge, pulse err, go to IDLE; rotation pointer not updated.
REQ-026 RELEASE: HREQ=0, DACK=0, grant_valid=0; stay until HLDA=0 sampled, then IDLE.
REQ-027 One grant per hold cycle: a new request is arbitrated only after returning through IDLE (minimum one IDLE cycle between grants).
REQ-028 eop outside GRANT shall be ignored.
REQ-029 Simultaneous eop and HLDA fall in GRANT: HLDA-loss path (REQ-025) takes precedence.
REQ-030 DACK shall never have more than one bit set; grant_valid=1 iff DACK != 0.

Reset
REQ-031 On reset low, immediately: state IDLE, HREQ=0, DACK=4'b0000, grant_ch=0, grant_valid=0, err=0, timeout counter 0, rotation pointer ch0-highest.
REQ-032 Reset asserted mid-GRANT aborts the grant without err pulse; release after reset resumes in IDLE on the next rising edge.

Verification
REQ-033 rotate=0, DREQ=4'b1010, mask=0, HLDA returned 2 cycles after HREQ -> DACK=4'b0010, grant_ch=1; eop -> RELEASE, HREQ=0, then HLDA low -> IDLE.
REQ-034 rotate=1, DREQ=4'b1111 held, eop after each grant -> grant order ch0, ch1, ch2, ch3, ch0.
REQ-035 DREQ=4'b0001, HLDA never asserted -> HREQ held exactly TIMEOUT cycles, then HREQ=0 and one-cycle err.
REQ-036 GRANT on ch2, HLDA dropped -> DACK=0, HREQ=0 next edge, err pulse, state IDLE; same cycle with eop -> identical response.
REQ-037 DREQ=4'b0100, mask=4'b0100 -> HREQ stays 0; DREQ withdrawn before HLDA in REQ -> no DACK, RELEASE then IDLE.
REQ-038 reset low during GRANT on ch3 -> all outputs zero asynchronously, no err; after release, pending DREQ re-arbitrated from IDLE.
